// File: rtl/scu_pkg.sv
// Shared opcode map, controller state type and register-usage decoders
// for the SCU pipeline control logic.
package scu_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_NEG  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_BRZ  = 4'b1001;
  localparam logic [3:0] OP_JM   = 4'b1010;
  localparam logic [3:0] OP_BRN  = 4'b1011;
  localparam logic [3:0] OP_LD   = 4'b1110;
  localparam logic [3:0] OP_SVPC = 4'b1111;

  localparam logic [3:0] NOP = OP_NOP;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  function automatic logic uses_rs(input logic [3:0] op);
    case (op)
      OP_LD, OP_ST, OP_ADD, OP_INC, OP_NEG, OP_SUB,
      OP_J, OP_JM, OP_BRZ, OP_BRN: uses_rs = 1'b1;
      default:                     uses_rs = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rt(input logic [3:0] op);
    case (op)
      OP_ST, OP_ADD, OP_SUB: uses_rt = 1'b1;
      default:               uses_rt = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register
// a load currently in EX is about to write.
module hazard_detect
  import scu_pkg::*;
(
  input  logic [3:0] i_id_opcode,
  input  logic [5:0] i_id_rs,
  input  logic [5:0] i_id_rt,
  input  logic [3:0] i_ex_opcode,
  input  logic [5:0] i_ex_rd,
  output logic       o_lu
);

  logic w_rs_hit;
  logic w_rt_hit;

  // A field only matters when the ID opcode actually reads it.
  assign w_rs_hit = uses_rs(i_id_opcode) && (i_ex_rd == i_id_rs);
  assign w_rt_hit = uses_rt(i_id_opcode) && (i_ex_rd == i_id_rt);
  assign o_lu     = (i_ex_opcode == OP_LD) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage SCU pipeline: stalls on
// load-use, squashes after taken branches, freezes on data-memory busy.
module pipeline_ctrl
  import scu_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       id_opcode,
  input  logic [5:0]       id_rs,
  input  logic [5:0]       id_rt,
  input  logic [3:0]       ex_opcode,
  input  logic [5:0]       ex_rd,
  input  logic             br_taken,
  input  logic             dmem_busy,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  // The branch cycle itself is the first squash, so FLUSH covers the rest.
  localparam int         FLUSH_LOAD_I = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;
  localparam logic [2:0] FLUSH_LOAD   = 3'(FLUSH_LOAD_I);
  localparam bit         USE_FLUSH    = (FLUSH_CYCLES > 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [2:0]       r_cnt;
  logic [2:0]       w_next_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_lu;

  hazard_detect u_hazard (
    .i_id_opcode (id_opcode),
    .i_id_rs     (id_rs),
    .i_id_rt     (id_rt),
    .i_ex_opcode (ex_opcode),
    .i_ex_rd     (ex_rd),
    .o_lu        (w_lu)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (!reset_n) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (!dmem_busy) begin
      case (r_state)
        ST_FLUSH: begin
          pc_we        = 1'b1;
          if_id_we     = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          if (r_cnt == 3'd0) begin
            w_next_state = ST_RUN;
          end else begin
            w_next_cnt = r_cnt - 3'd1;
          end
        end
        // RUN, LU_STALL and the unused encoding share one decision tree;
        // LU_STALL differs only in suppressing the hazard check.
        default: begin
          if (br_taken) begin
            pc_we        = 1'b1;
            if_id_we     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            if (USE_FLUSH) begin
              w_next_state = ST_FLUSH;
              w_next_cnt   = FLUSH_LOAD;
            end else begin
              w_next_state = ST_RUN;
            end
          end else if (w_lu && (r_state != ST_LU_STALL)) begin
            id_ex_bubble = 1'b1;
            w_next_state = ST_LU_STALL;
          end else begin
            pc_we        = 1'b1;
            if_id_we     = 1'b1;
            w_next_state = ST_RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (!pc_we && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the 5-stage SCU pipeline. It watches the instruction held in the IF/ID buffer, the instruction in ID/EX, branch resolution from EX, and data-memory readiness. It drives the enables and flushes that stall, squash or freeze the PC, the IF/ID buffer and the ID/EX buffer. It also keeps a saturating count of stall cycles for performance measurement.

## Interface
Parameters:
- FLUSH_CYCLES, 2: cycles of IF/ID squash after a taken branch/jump (legal 1..7).
- CNT_W, 16: width of `stall_cnt`.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- id_opcode  in  4  opcode of the instruction in ID (IF/ID buffer output).
- id_rs  in  6  rs field in ID.
- id_rt  in  6  rt field in ID.
- ex_opcode  in  4  opcode of the instruction in EX (ID/EX buffer output).
- ex_rd  in  6  rd field in EX.
- br_taken  in  1  EX has resolved a taken BRZ/BRN or an executed J/JM this cycle.
- dmem_busy  in  1  data memory not ready; the whole pipeline must hold.
- pc_we  out  1  PC register write enable.
- if_id_we  out  1  IF/ID buffer load enable.
- if_id_flush  out  1  IF/ID buffer loads NOP (opcode 0000) instead of `instr`.
- id_ex_bubble  out  1  ID/EX buffer loads NOP instead of the decoded instruction.
- state  out  2  current FSM state (debug).
- stall_cnt  out  CNT_W  saturating count of cycles with `pc_we`=0 since reset.

## Operation
- Opcodes: NOP 0000, ST 0011, ADD 0100, INC 0101, NEG 0110, SUB 0111, J 1000, BRZ 1001, JM 1010, BRN 1011, LD 1110, SVPC 1111.
- Reads rs: LD, ST, ADD, INC, NEG, SUB, J, JM, BRZ, BRN. Reads rt: ST, ADD, SUB.
- Load-use hazard (`lu`): ex_opcode==LD and ((ID reads rs and ex_rd==id_rs) or (ID reads rt and ex_rd==id_rt)).
- States: RUN=0, LU_STALL=1, FLUSH=2. Encoding 3 is unreachable and decodes as RUN.
- Outputs are combinational from state and inputs. State, flush counter and stall_cnt are registered.
- Priority each cycle: dmem_busy, then br_taken, then lu.
- dmem_busy=1, any state:
  - All four outputs are 0: pc_we, if_id_we, if_id_flush, id_ex_bubble.
  - State and flush counter hold.
  - br_taken and lu are ignored.
- RUN:
  - br_taken: pc_we=1, if_id_we=1, if_id_flush=1, id_ex_bubble=1.
    - FLUSH_CYCLES>1: go to FLUSH, cnt=FLUSH_CYCLES-2.
    - FLUSH_CYCLES==1: stay in RUN.
  - Else lu: pc_we=0, if_id_we=0, id_ex_bubble=1; go to LU_STALL.
  - Else: pc_we=1, if_id_we=1, flush=0, bubble=0.
- LU_STALL:
  - Hazard check is suppressed.
  - br_taken is handled exactly as in RUN.
  - Otherwise outputs are as in RUN-normal; go to RUN.
- FLUSH:
  - pc_we=1, if_id_we=1, if_id_flush=1, id_ex_bubble=1.
  - br_taken and lu are ignored, because those instructions are squashed.
  - cnt==0: go to RUN; else cnt--.
- stall_cnt increments by 1 on every clock edge where pc_we==0 (including dmem_busy cycles). It saturates at 2^CNT_W-1.

## Timing
- Hazard, branch and busy responses have zero-cycle latency: outputs react in the same cycle as the inputs.
- A load-use hazard costs exactly 1 stall cycle.
- A taken branch squashes exactly FLUSH_CYCLES consecutive IF/ID loads, counting the br_taken cycle.
- While reset_n=0:
  - state=RUN, cnt=0, stall_cnt=0.
  - pc_we=0, if_id_we=0, if_id_flush=1, id_ex_bubble=1.
- Reset mid-FLUSH or mid-LU_STALL aborts immediately. The first cycle after deassertion is RUN.
- dmem_busy during FLUSH extends the flush window by the busy duration, and no squash cycles are lost.
- br_taken coincident with lu in RUN: the branch wins and there is no LU_STALL.
- If ex_rd matches a register that ID does not read, there is no stall (e.g. INC ignores rt).

## Structure
- Package `scu_pkg` holds:
  - opcode localparams;
  - state enum (RUN/LU_STALL/FLUSH);
  - functions `uses_rs(opcode)` and `uses_rt(opcode)`;
  - NOP constant.
- One sub-module, `hazard_detect`: combinational, produces `lu` from id_opcode/id_rs/id_rt/ex_opcode/ex_rd.
- The FSM, flush counter and stall_cnt live in pipeline_ctrl.

## Test plan
- Reset: hold reset_n=0 for 3 cycles. Expect pc_we=0, if_id_flush=1, state=0, stall_cnt=0. After release with NOPs, expect pc_we=1 and if_id_we=1.
- Load-use: ex=LD rd=5, id=ADD rs=5 rt=2. Expect one cycle of pc_we=0, if_id_we=0, id_ex_bubble=1 and stall_cnt=1, then RUN.
- No false hazard: ex=LD rd=7, id=INC rs=3 rt=7. Expect no stall.
- Taken branch with FLUSH_CYCLES=2: br_taken pulse. Expect if_id_flush=1 for 2 cycles (state 0→2→0). A second br_taken during FLUSH is ignored.
- dmem_busy for 4 cycles mid-FLUSH: all outputs 0 and state held at 2 while busy. The remaining flush cycle follows, and stall_cnt is +4.
- Priority and saturation:
  - br_taken and lu together: branch response, no LU_STALL.
  - With CNT_W=4, 20 busy cycles leave stall_cnt=15.
